// File: rtl/page_leaf_pkg.sv
// Shared constants and helpers for the loopback leaf page.
package page_leaf_pkg;

  localparam int unsigned DEF_PKT_W = 49;
  localparam int unsigned VALID_BIT = DEF_PKT_W - 1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/page_leaf_chan.sv
// One leaf channel: packet FIFO, start latch, resend replay and sticky overflow.
module page_leaf_chan
  import page_leaf_pkg::*;
#(
  parameter int unsigned PKT_W = DEF_PKT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PKT_W-1:0] din,
  input  logic             resend,
  input  logic             ap_start,
  output logic [PKT_W-1:0] dout,
  output logic             overflow
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned VLD    = PKT_W - 1;

  logic [PKT_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              started;
  logic [PKT_W-1:0]  last_sent;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;

  // A pop at the same edge frees a slot, so a full FIFO still accepts the push.
  always_comb begin
    full  = (count == (ADDR_W+1)'(DEPTH));
    empty = (count == '0);
    pop   = !resend && started && !empty;
    push  = din[VLD] && (!full || pop);
    drop  = din[VLD] && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      started   <= 1'b0;
      last_sent <= '0;
      overflow  <= 1'b0;
      dout      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      if (ap_start) started  <= 1'b1;
      if (drop)     overflow <= 1'b1;
      if (resend) begin
        dout <= last_sent;
      end else if (pop) begin
        dout      <= mem[rd_ptr];
        last_sent <= mem[rd_ptr];
      end else begin
        dout <= '0;
      end
    end
  end

endmodule

// File: rtl/page_leaf_loopback.sv
// Loopback leaf page: NUM_CH independent leaf channels sharing one clock.
module page_leaf_loopback
  import page_leaf_pkg::*;
#(
  parameter int unsigned NUM_CH = 6,
  parameter int unsigned PKT_W  = DEF_PKT_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH*PKT_W-1:0] din_leaf_bft2interface,
  output logic [NUM_CH*PKT_W-1:0] dout_leaf_interface2bft,
  input  logic [NUM_CH-1:0]       resend,
  input  logic [NUM_CH-1:0]       ap_start,
  output logic [NUM_CH-1:0]       overflow
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    page_leaf_chan #(
      .PKT_W (PKT_W),
      .DEPTH (DEPTH)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .din      (din_leaf_bft2interface[g*PKT_W +: PKT_W]),
      .resend   (resend[g]),
      .ap_start (ap_start[g]),
      .dout     (dout_leaf_interface2bft[g*PKT_W +: PKT_W]),
      .overflow (overflow[g])
    );
  end

endmodule

// File: tb/tb_page_leaf_loopback.sv
// Directed and randomized checks of page_leaf_loopback against a queue-based reference model.
module tb_page_leaf_loopback;

  localparam int unsigned NUM_CH = 6;
  localparam int unsigned PKT_W  = 49;
  localparam int unsigned DEPTH  = 4;

  logic                    clk;
  logic                    reset_n;
  logic [NUM_CH*PKT_W-1:0] din;
  logic [NUM_CH*PKT_W-1:0] dout;
  logic [NUM_CH-1:0]       resend;
  logic [NUM_CH-1:0]       ap_start;
  logic [NUM_CH-1:0]       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [PKT_W-1:0] mq [NUM_CH][$];
  logic [PKT_W-1:0] m_last [NUM_CH];
  logic [PKT_W-1:0] m_dout [NUM_CH];
  logic [NUM_CH-1:0] m_started;
  logic [NUM_CH-1:0] m_ovf;

  page_leaf_loopback #(
    .NUM_CH (NUM_CH),
    .PKT_W  (PKT_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .din_leaf_bft2interface  (din),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend),
    .ap_start                (ap_start),
    .overflow                (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_last[c] = '0;
      m_dout[c] = '0;
    end
    m_started = '0;
    m_ovf     = '0;
  endtask

  // Applies one clock edge of the behavioural rules using the pre-edge inputs.
  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      logic [PKT_W-1:0] pkt;
      pkt = din[c*PKT_W +: PKT_W];
      if (resend[c]) begin
        m_dout[c] = m_last[c];
      end else if (m_started[c] && mq[c].size() > 0) begin
        m_dout[c] = mq[c].pop_front();
        m_last[c] = m_dout[c];
      end else begin
        m_dout[c] = '0;
      end
      if (pkt[PKT_W-1]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(pkt);
        else m_ovf[c] = 1'b1;
      end
      if (ap_start[c]) m_started[c] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NUM_CH; c++)
      check_eq($sformatf("dout_ch%0d", c), 64'(dout[c*PKT_W +: PKT_W]), 64'(m_dout[c]));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic clear_inputs();
    din      = '0;
    resend   = '0;
    ap_start = '0;
  endtask

  task automatic set_din(input int c, input logic [PKT_W-1:0] v);
    din[c*PKT_W +: PKT_W] = v;
  endtask

  function automatic logic [PKT_W-1:0] rand_pkt(input logic vld);
    logic [63:0] r;
    logic [PKT_W-1:0] p;
    r = {$urandom(), $urandom()};
    p = r[PKT_W-1:0];
    p[PKT_W-1] = vld;
    return p;
  endfunction

  logic [PKT_W-1:0] pkt_a, pkt_b, pkt_c;
  logic [PKT_W-1:0] p2 [5];

  initial begin
    pkt_a = 49'h1_0000_0000_00AA;
    pkt_b = 49'h1_2345_6789_0AB;
    pkt_b[PKT_W-1] = 1'b1;
    pkt_c = rand_pkt(1'b1);
    clear_inputs();
    reset_n = 1'b0;
    model_reset();
    #12;
    check_outputs();
    reset_n = 1'b1;
    step();

    // 1: single packet on ch0, one edge latency then idle
    ap_start[0] = 1'b1;
    step();
    clear_inputs();
    set_din(0, pkt_a);
    step();
    clear_inputs();
    step();
    check_eq("t1_pkt", 64'(dout[0 +: PKT_W]), 64'(pkt_a));
    step();
    check_eq("t1_idle", 64'(dout[0 +: PKT_W]), 64'd0);

    // 2: unstarted ch2 overflows, then drains P1..P4
    for (int i = 0; i < 5; i++) begin
      p2[i] = rand_pkt(1'b1);
      set_din(2, p2[i]);
      step();
    end
    clear_inputs();
    check_eq("t2_ovf", 64'(overflow[2]), 64'd1);
    check_eq("t2_quiet", 64'(dout[2*PKT_W +: PKT_W]), 64'd0);
    ap_start[2] = 1'b1;
    step();
    clear_inputs();
    step();
    check_eq("t2_first", 64'(dout[2*PKT_W +: PKT_W]), 64'(p2[0]));
    for (int i = 0; i < 5; i++) step();

    // 3: resend on ch1 holds replay, queued packet follows
    ap_start[1] = 1'b1;
    set_din(1, pkt_b);
    step();
    clear_inputs();
    step();
    for (int i = 0; i < 3; i++) begin
      resend[1] = 1'b1;
      if (i == 1) set_din(1, pkt_c);
      step();
      clear_inputs();
      check_eq("t3_replay", 64'(dout[PKT_W +: PKT_W]), 64'(pkt_b));
    end
    step();
    check_eq("t3_after", 64'(dout[PKT_W +: PKT_W]), 64'(pkt_c));
    step();

    // 4: resend before emission, then push+pop while full
    resend[3] = 1'b1;
    step();
    clear_inputs();
    check_eq("t4_resend0", 64'(dout[3*PKT_W +: PKT_W]), 64'd0);
    for (int i = 0; i < 4; i++) begin
      set_din(3, rand_pkt(1'b1));
      step();
    end
    clear_inputs();
    ap_start[3] = 1'b1;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      set_din(3, rand_pkt(1'b1));
      step();
    end
    clear_inputs();
    check_eq("t4_no_ovf", 64'(overflow[3]), 64'd0);
    for (int i = 0; i < 6; i++) step();

    // 5: asynchronous reset with ch4 holding packets
    for (int i = 0; i < 3; i++) begin
      set_din(4, rand_pkt(1'b1));
      step();
    end
    clear_inputs();
    ap_start[4] = 1'b1;
    step();
    clear_inputs();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("t5_dout", 64'(|dout), 64'd0);
    check_eq("t5_ovf", 64'(overflow), 64'd0);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("t5_silent", 64'(dout[4*PKT_W +: PKT_W]), 64'd0);
    ap_start[4] = 1'b1;
    set_din(4, rand_pkt(1'b1));
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) step();

    // 6: all channels, random valid gaps, occasional resend and junk
    ap_start = '1;
    step();
    for (int n = 0; n < 1500; n++) begin
      clear_inputs();
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(3) != 0) set_din(c, rand_pkt(1'b1));
        else set_din(c, rand_pkt(1'b0));
        resend[c] = ($urandom_range(15) == 0);
      end
      ap_start = NUM_CH'($urandom());
      step();
    end
    clear_inputs();
    for (int i = 0; i < 2 * DEPTH; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
